// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, status word bit positions, baud divider helper.
// UART_RX_PARITY_EN adds the PARITY state used by the 8E1 receiver build.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
`else
      ST_STOP   = 3'd3
`endif
   } uart_rx_state_t;

   localparam int UART_ST_VALID = 8;
   localparam int UART_ST_FERR  = 9;
   localparam int UART_ST_OVR   = 10;
   localparam int UART_ST_PERR  = 11;

   function automatic int uart_clks_per_bit(input int f_clk, input int baud);
      return f_clk / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter
// so idle-high lines (UART) and idle-low lines (buttons) both come out of reset quiet.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         q      <= RST_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver bus slave: 8N1 frames into a one-byte holding register with sticky status.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err flag in bit 11.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUDRATE = 115200,
   parameter int F_CLK    = 576000
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        uart_rx_i,
   input  logic        uart_rd_i,
   output logic [31:0] uart_data_o
);

   localparam int CLKS_PER_BIT = uart_clks_per_bit(F_CLK, BAUDRATE);
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx: F_CLK/BAUDRATE must be at least 4");
   end

   logic rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (sys_clk_i),
      .rst_n (sys_rst_i),
      .d     (uart_rx_i),
      .q     (rx_s)
   );

   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           done;
   logic           stop_bad;

   logic [7:0]     data_q;
   logic           valid_q;
   logic           ferr_q;
   logic           ovr_q;
   // Set by a framing error; holds off new starts until the line returns high.
   logic           brk_q;

`ifdef UART_RX_PARITY_EN
   logic           perr_q;
   logic           par_pend_q, par_pend_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      done     = 1'b0;
      stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_d = par_pend_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_s && !brk_q) begin
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               par_pend_d = ^{shift_q, rx_s};
               state_d    = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               done     = 1'b1;
               stop_bad = !rx_s;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Frame completion beats a same-edge read: old flags are dropped, new ones kept.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
         par_pend_q <= 1'b0;
`endif
      end else begin
`ifdef UART_RX_PARITY_EN
         par_pend_q <= par_pend_d;
`endif
         if (done && stop_bad) begin
            brk_q <= 1'b1;
         end else if (rx_s) begin
            brk_q <= 1'b0;
         end
         if (done) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            ferr_q  <= (ferr_q & !uart_rd_i) | stop_bad;
            ovr_q   <= (ovr_q | valid_q) & !uart_rd_i;
`ifdef UART_RX_PARITY_EN
            perr_q  <= (perr_q & !uart_rd_i) | par_pend_q;
`endif
         end else if (uart_rd_i) begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
         end
      end
   end

   always_comb begin
      uart_data_o                = '0;
      uart_data_o[7:0]           = data_q;
      uart_data_o[UART_ST_VALID] = valid_q;
      uart_data_o[UART_ST_FERR]  = ferr_q;
      uart_data_o[UART_ST_OVR]   = ovr_q;
`ifdef UART_RX_PARITY_EN
      uart_data_o[UART_ST_PERR]  = perr_q;
`endif
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; parity vectors run when UART_RX_PARITY_EN is set.
module tb_uart_rx;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic        rd;
   logic [31:0] data;

   int tests = 0;
   int fails = 0;

   uart_rx #(.BAUDRATE(115200), .F_CLK(1152000)) dut (
      .sys_clk_i   (clk),
      .sys_rst_i   (rst_n),
      .uart_rx_i   (rx),
      .uart_rd_i   (rd),
      .uart_data_o (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic line(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Start bit, 8 data bits LSB first, optional parity, then stop held for stop_clks clocks.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int stop_clks);
      line(1'b0, 10);
      for (int i = 0; i < 8; i++) line(d[i], 10);
`ifdef UART_RX_PARITY_EN
      line(par, 10);
`else
      if (par === 1'bx) rx = 1'b0;
`endif
      line(stop, stop_clks);
   endtask

   task automatic do_read();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      rd    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", data, 32'h0000_0000);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // single frame: stop sampled on the 98th edge after the start bit
      send_frame(8'hA5, 1'b1, 1'b0, 7);
      check("a5_before_stop", data, 32'h0000_0000);
      @(negedge clk);
      check("a5_valid", data, 32'h0000_01A5);
      line(1'b1, 5);
      do_read();
      check("a5_read", data, 32'h0000_00A5);

      // reset in the middle of 0x55
      line(1'b0, 10);
      line(1'b1, 10);
      line(1'b0, 10);
      line(1'b1, 10);
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      check("rst_async", data, 32'h0000_0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      line(1'b1, 20);
      check("rst_idle", data, 32'h0000_0000);
      send_frame(8'h12, 1'b1, 1'b0, 10);
      check("rx_12", data, 32'h0000_0112);
      do_read();
      check("rd_12", data, 32'h0000_0012);

      // glitch shorter than half a bit
      line(1'b0, 3);
      line(1'b1, 30);
      check("glitch", data, 32'h0000_0012);

      // framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0, 10);
      check("ferr", data, 32'h0000_033C);
      line(1'b0, 30);
      check("break_hold", data, 32'h0000_033C);
      line(1'b1, 10);
      do_read();
      check("ferr_read", data, 32'h0000_003C);
      send_frame(8'h01, 1'b1, 1'b1, 10);
      check("rx_01", data, 32'h0000_0101);
      do_read();

      // overrun, second start right after the stop midpoint
      send_frame(8'h11, 1'b1, 1'b0, 8);
      send_frame(8'h22, 1'b1, 1'b0, 10);
      check("overrun", data, 32'h0000_0522);
      send_frame(8'h33, 1'b1, 1'b0, 7);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("rd_on_done", data, 32'h0000_0133);
      line(1'b1, 5);
      do_read();
      check("rd_after", data, 32'h0000_0033);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 10);
      check("par_ok", data, 32'h0000_0107);
      do_read();
      send_frame(8'h07, 1'b1, 1'b0, 10);
      check("par_err", data, 32'h0000_0907);
      do_read();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
